// File: rtl/r4u1_seq_ctrl_pkg.sv
// Shared definitions for the radix-4 unit-1 sequencer and the twiddle-unit
// ROM-address logic: state codes, legal ldn range and the ldn -> S mapping.
package r4u1_seq_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0] LDN_MIN = 4'd4;
  localparam logic [3:0] LDN_MAX = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH
  } state_e;

  // log2 of the sub-block length: 32-point sub-blocks for odd ldn, 16 for even.
  function automatic logic [2:0] ldn_to_s(input logic [3:0] ldn);
    return ldn[0] ? 3'd5 : 3'd4;
  endfunction

endpackage

// File: rtl/r4u1_lat_cnt.sv
// Post-block latency counter: load_i arms it, expire_o pulses PIPE_LAT cycles
// later (counting the first armed cycle as lc = 0).
module r4u1_lat_cnt #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic load_i,
  output logic expire_o
);

  logic [2:0] lc_q, lc_d;
  logic       act_q, act_d;

  assign expire_o = act_q && (lc_q == 3'(PIPE_LAT - 1));

  always_comb begin
    lc_d  = lc_q;
    act_d = act_q;
    if (load_i) begin
      lc_d  = '0;
      act_d = 1'b1;
    end else if (expire_o) begin
      lc_d  = '0;
      act_d = 1'b0;
    end else if (act_q) begin
      lc_d = lc_q + 3'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      lc_q  <= '0;
      act_q <= 1'b0;
    end else begin
      lc_q  <= lc_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/r4u1_seq_ctrl.sv
// Sequencer for the radix-4 unit-1 twiddle stage: counts samples per N-point
// block and issues block/stage syncs and k1/k2 selects aligned with the data.
module r4u1_seq_ctrl
  import r4u1_seq_ctrl_pkg::*;
#(
  parameter int CNT_W    = 11,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       start_i,
  input  logic [3:0] ldn_rg_i,
  input  logic       data_val_i,
  output logic       block_sync_o,
  output logic       stage_sync_o,
  output logic       data_val_o,
  output logic       k1_o,
  output logic       k2_o,
  output logic [3:0] ldn_rg_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ldn_q, ldn_d;
  logic             bs_q, bs_d, ss_q, ss_d, dv_q, dv_d;
  logic             k1_q, k1_d, k2_q, k2_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             legal, start_ok, start_bad, accept, last, expire;
  logic [3:0]       ldn_eff;
  logic [2:0]       s_eff;
  logic [CNT_W-1:0] cnt_eff, last_idx, sub_mask, k_sh;

  r4u1_lat_cnt #(.PIPE_LAT(PIPE_LAT)) u_lat_cnt (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .load_i   (accept && last),
    .expire_o (expire)
  );

  // A legal start takes effect in the same cycle, so a coincident sample is
  // evaluated against the new ldn with the counter already at zero.
  always_comb begin
    legal     = (ldn_rg_i >= LDN_MIN) && (ldn_rg_i <= LDN_MAX);
    start_ok  = start_i && legal;
    start_bad = start_i && !legal;
    ldn_eff   = start_ok ? ldn_rg_i : ldn_q;
    cnt_eff   = start_ok ? '0 : cnt_q;
    s_eff     = ldn_to_s(ldn_eff);
    last_idx  = CNT_W'((32'd1 << ldn_eff) - 32'd1);
    sub_mask  = CNT_W'((32'd1 << s_eff) - 32'd1);
    k_sh      = cnt_eff >> (s_eff - 3'd2);
    accept    = data_val_i && (start_ok || (state_q == S_RUN));
    last      = (cnt_eff == last_idx);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_eff;
    ldn_d   = ldn_eff;
    k1_d    = k1_q;
    k2_d    = k2_q;
    bs_d    = 1'b0;
    ss_d    = 1'b0;
    dv_d    = 1'b0;
    done_d  = expire;
    err_d   = start_bad || (start_ok && (state_q == S_RUN) && (cnt_q != '0));

    if (start_ok) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (accept && last) state_d = S_FLUSH;
        S_FLUSH: if (expire) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end

    if (accept) begin
      dv_d  = 1'b1;
      bs_d  = (cnt_eff == '0);
      ss_d  = ((cnt_eff & sub_mask) == '0);
      k1_d  = k_sh[0];
      k2_d  = k_sh[1];
      cnt_d = last ? '0 : cnt_eff + CNT_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ldn_q   <= '0;
      bs_q    <= 1'b0;
      ss_q    <= 1'b0;
      dv_q    <= 1'b0;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldn_q   <= ldn_d;
      bs_q    <= bs_d;
      ss_q    <= ss_d;
      dv_q    <= dv_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign block_sync_o = bs_q;
  assign stage_sync_o = ss_q;
  assign data_val_o   = dv_q;
  assign k1_o         = k1_q;
  assign k2_o         = k2_q;
  assign ldn_rg_o     = ldn_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_r4u1_seq_ctrl.sv
// Bench for r4u1_seq_ctrl: directed scenarios plus random traffic, compared
// every cycle against a sample-index reference model.
module tb_r4u1_seq_ctrl;

  localparam int CNT_W    = 11;
  localparam int PIPE_LAT = 2;

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       start_i;
  logic [3:0] ldn_rg_i;
  logic       data_val_i;
  logic       block_sync_o, stage_sync_o, data_val_o, k1_o, k2_o;
  logic [3:0] ldn_rg_o;
  logic       busy_o, done_o, err_o;

  always #5 clk_sys = ~clk_sys;

  r4u1_seq_ctrl #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .start_i      (start_i),
    .ldn_rg_i     (ldn_rg_i),
    .data_val_i   (data_val_i),
    .block_sync_o (block_sync_o),
    .stage_sync_o (stage_sync_o),
    .data_val_o   (data_val_o),
    .k1_o         (k1_o),
    .k2_o         (k2_o),
    .ldn_rg_o     (ldn_rg_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position inside the current block plus a countdown to done.
  bit   m_run;
  int   m_idx, m_ldn, m_left, m_k;
  logic e_bs, e_ss, e_dv, e_done, e_err;

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_ldn = 0; m_left = 0; m_k = 0;
    e_bs = 0; e_ss = 0; e_dv = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step(input bit st, input int ldn, input bit dv);
    int n, l;
    e_done = 0; e_err = 0; e_bs = 0; e_ss = 0; e_dv = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) e_done = 1;
    end
    if (st && (ldn < 4 || ldn > 11)) begin
      e_err = 1;
    end else if (st) begin
      if (m_run && m_idx != 0) e_err = 1;
      m_run = 1; m_idx = 0; m_ldn = ldn;
    end
    if (dv && m_run) begin
      n = 1 << m_ldn;
      l = (m_ldn % 2 == 1) ? 32 : 16;
      e_dv = 1;
      e_bs = (m_idx == 0);
      e_ss = (m_idx % l == 0);
      m_k  = (m_idx % l) / (l / 4);
      m_idx++;
      if (m_idx == n) begin
        m_idx = 0; m_run = 0; m_left = PIPE_LAT;
      end
    end
  endtask

  function automatic logic [12:0] obs();
    return {block_sync_o, stage_sync_o, data_val_o, k2_o, k1_o, ldn_rg_o, busy_o, done_o, err_o};
  endfunction

  function automatic logic [12:0] expv();
    logic [1:0] k;
    logic [3:0] ld;
    k  = 2'(m_k);
    ld = 4'(m_ldn);
    return {e_bs, e_ss, e_dv, k, ld, (m_run || m_left > 0), e_done, e_err};
  endfunction

  task automatic cyc(input string tag, input bit st, input int ldn, input bit dv);
    start_i    = st;
    ldn_rg_i   = 4'(ldn);
    data_val_i = dv;
    model_step(st, ldn, dv);
    @(posedge clk_sys);
    #1;
    chk(tag, 32'(obs()), 32'(expv()));
  endtask

  initial begin
    rst_sys = 1'b1; start_i = 1'b0; ldn_rg_i = '0; data_val_i = 1'b0;
    model_reset();
    #2;
    chk("reset", 32'(obs()), 32'd0);
    #10 rst_sys = 1'b0;
    @(posedge clk_sys);
    #1;

    // N=16, back-to-back samples
    cyc("n16", 1, 4, 1);
    for (int i = 1; i < 16; i++) cyc("n16", 0, 4, 1);
    for (int i = 0; i < 4; i++) cyc("n16_tail", 0, 4, 0);

    // N=128, ldn_rg_i wandering mid-block
    cyc("n128", 1, 7, 1);
    for (int i = 1; i < 128; i++) cyc("n128", 0, int'($urandom_range(0, 15)), 1);
    for (int i = 0; i < 4; i++) cyc("n128_tail", 0, 7, 0);

    // N=32 with alternating gaps
    cyc("n32gap", 1, 5, 1);
    for (int i = 1; i < 63; i++) cyc("n32gap", 0, 5, (i % 2) == 0);
    for (int i = 0; i < 4; i++) cyc("n32gap_tail", 0, 5, 0);

    // illegal ldn, and data without start
    cyc("bad_ldn3", 1, 3, 0);
    cyc("idle", 0, 3, 0);
    cyc("bad_ldn12", 1, 12, 1);
    for (int i = 0; i < 3; i++) cyc("stray_dv", 0, 5, 1);

    // abort at cnt=20, then a start inside FLUSH
    cyc("abort", 1, 6, 1);
    for (int i = 1; i < 20; i++) cyc("abort", 0, 6, 1);
    cyc("restart", 1, 6, 1);
    for (int i = 1; i < 64; i++) cyc("blk_a", 0, 6, 1);
    cyc("flush_start", 1, 6, 1);
    for (int i = 1; i < 64; i++) cyc("blk_b", 0, 6, 1);
    for (int i = 0; i < 4; i++) cyc("blk_b_tail", 0, 6, 0);

    // asynchronous reset at cnt=9
    cyc("pre_rst", 1, 8, 1);
    for (int i = 1; i < 9; i++) cyc("pre_rst", 0, 8, 1);
    #3 rst_sys = 1'b1;
    #1;
    chk("rst_async", 32'(obs()), 32'd0);
    model_reset();
    @(posedge clk_sys);
    #1 rst_sys = 1'b0;
    for (int i = 0; i < 5; i++) cyc("post_rst_dv", 0, 8, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit st, dv;
      int ldn;
      st  = ($urandom_range(0, 99) < 2);
      ldn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(4, 6));
      dv  = ($urandom_range(0, 3) != 0);
      cyc("rand", st, ldn, dv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
